fifo_sync_param: RTL and testbench

FIFO_SYNC_PARAM -- requirements
Module: fifo_sync_param

---
 rtl/fifo_sync_param.sv | 85 ++++++++
 tb/tb_fifo_sync_param.sv | 105 ++++++++++
 2 files changed

// File: rtl/fifo_sync_param.sv
// Synchronous FIFO with registered full/empty/almost flags, sticky overflow/underflow.
// Define FIFO_SYNC_PARAM_FWFT_EN for first-word-fall-through output; default is registered one-cycle read.
module fifo_sync_param #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 3,
  parameter int AF_LEVEL   = (2**DEPTH_LOG2) - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_to_stack,
  input  logic                  read_from_stack,
  input  logic [WIDTH-1:0]      Data_in,
  output logic [WIDTH-1:0]      Data_out,
  output logic                  stack_full,
  output logic                  stack_empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int DEPTH = 2**DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [DEPTH_LOG2-1:0]       wr_ptr, rd_ptr;
  logic                        rd_ok, wr_ok;
  logic [CW-1:0]               cnt_nxt;

  // A read frees a slot in the same edge, so a full FIFO still takes a paired write.
  assign rd_ok = read_from_stack & ~stack_empty;
  assign wr_ok = write_to_stack & (~stack_full | rd_ok);

  always_comb begin
    cnt_nxt = count;
    case ({wr_ok, rd_ok})
      2'b10:   cnt_nxt = count + 1'b1;
      2'b01:   cnt_nxt = count - 1'b1;
      default: cnt_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_ok) mem[wr_ptr] <= Data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      stack_full   <= 1'b0;
      stack_empty  <= 1'b1;
      almost_full  <= (AF_LEVEL == 0);
      almost_empty <= 1'b1;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      count        <= cnt_nxt;
      stack_full   <= (cnt_nxt == DEPTH_C);
      stack_empty  <= (cnt_nxt == '0);
      almost_full  <= (cnt_nxt >= AF_C);
      almost_empty <= (cnt_nxt <= AE_C);
      if (write_to_stack && !wr_ok) overflow  <= 1'b1;
      if (read_from_stack && !rd_ok) underflow <= 1'b1;
    end
  end

`ifdef FIFO_SYNC_PARAM_FWFT_EN
  // Head word is visible straight from storage; forced to zero while empty.
  assign Data_out = stack_empty ? '0 : mem[rd_ptr];
`else
  always_ff @(posedge clk) begin
    if (rst)        Data_out <= '0;
    else if (rd_ok) Data_out <= mem[rd_ptr];
  end
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// Scoreboard bench for fifo_sync_param: directed scenarios then random traffic vs a queue model.
module tb_fifo_sync_param;
  localparam int W = 8;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         rst, wr, rd;
  logic [W-1:0] din, dout;
  logic         full, empty, afull, aempty, ovf, unf;
  logic [3:0]   cnt;

  fifo_sync_param #(.WIDTH(W), .DEPTH_LOG2(3)) dut (
    .clk(clk), .rst(rst), .write_to_stack(wr), .read_from_stack(rd),
    .Data_in(din), .Data_out(dout), .stack_full(full), .stack_empty(empty),
    .almost_full(afull), .almost_empty(aempty), .count(cnt),
    .overflow(ovf), .underflow(unf)
  );

  always #5 clk = ~clk;

  // Reference model: contents as a queue, sticky flags, words delivered by reads.
  logic [W-1:0] mq[$];
  logic [W-1:0] sb[$];
  logic [W-1:0] last_rd = '0;
  bit           m_ovf = 0, m_unf = 0, started = 0;
  int           tests = 0, fails = 0;

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic cyc(input bit rs, input bit w, input bit r, input logic [W-1:0] d);
    bit rok, wok;
    rst = rs; wr = w; rd = r; din = d;
    @(posedge clk);
    if (rs) begin
      mq.delete(); sb.delete(); m_ovf = 0; m_unf = 0; last_rd = '0;
    end else begin
      rok = r && (mq.size() > 0);
      wok = w && (mq.size() < D || rok);
      if (rok) sb.push_back(mq.pop_front());
      if (wok) mq.push_back(d);
      if (w && !wok) m_ovf = 1;
      if (r && !rok) m_unf = 1;
    end
    started = 1;
    @(negedge clk); #1;
  endtask

  always @(negedge clk) begin
    int n;
    logic [W-1:0] exp_d;
    if (started) begin
      n = mq.size();
      chk("count", int'(cnt), n);
      chk("stack_full", int'(full), int'(n == D));
      chk("stack_empty", int'(empty), int'(n == 0));
      chk("almost_full", int'(afull), int'(n >= D - 1));
      chk("almost_empty", int'(aempty), int'(n <= 1));
      chk("overflow", int'(ovf), int'(m_ovf));
      chk("underflow", int'(unf), int'(m_unf));
`ifdef FIFO_SYNC_PARAM_FWFT_EN
      sb.delete();
      exp_d = (n > 0) ? mq[0] : '0;
`else
      if (sb.size() > 0) last_rd = sb.pop_front();
      exp_d = last_rd;
`endif
      chk("Data_out", int'(dout), int'(exp_d));
    end
  end

  initial begin
    rst = 1; wr = 0; rd = 0; din = '0;
    cyc(1, 0, 0, 8'h00);                                   // reset state
    for (int i = 1; i <= 8; i++) cyc(0, 1, 0, W'(i));      // fill 0x01..0x08
    cyc(0, 1, 0, 8'hFF);                                   // refused: overflow
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 8'h00);       // drain in order
    cyc(0, 0, 1, 8'h00);                                   // refused: underflow
    cyc(1, 0, 0, 8'h00);
    for (int i = 1; i <= 8; i++) cyc(0, 1, 0, W'(i + 16));
    cyc(0, 1, 1, 8'hAA);                                   // full read+write
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 8'h00);       // ends with 0xAA
    cyc(0, 1, 1, 8'h55);                                   // empty read+write
    cyc(0, 0, 0, 8'h00);
    cyc(1, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, W'(8'h30 + i));
    cyc(1, 1, 0, 8'h77);                                   // reset beats write
    cyc(0, 0, 1, 8'h00);
    for (int i = 0; i < 600; i++) begin
      int mode = i / 150;
      bit w = ($urandom_range(99) < (mode == 1 ? 80 : (mode == 2 ? 20 : 50)));
      bit r = ($urandom_range(99) < (mode == 1 ? 20 : (mode == 2 ? 80 : 50)));
      bit rs = ($urandom_range(199) == 0);
      cyc(rs, w, r, W'($urandom));
    end
    cyc(0, 0, 0, 8'h00);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
